rf_wport_arb: RTL and testbench
===============================

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 Parameter: STARVE_LIM, default 4, number of consecutive cycles a pending B entry may lose arbitration before A is stalled (range 1..15).
REQ-002 Port list, one per line (name  direction  width  meaning):
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- a_valid  in  1  pipeline writeback request valid.
- a_ready  out  1  arbiter accepts A this cycle.
- a_we  in  1  A carries a register write.
- a_waddr  in  5  A destination register.
- a_wdata  in  32  A write data.
- b_valid  in  1  long-latency unit (mul/div) result valid.
- b_ready  out  1  B result buffer has space.
- b_waddr  in  5  B destination register.
- b_wdata  in  32  B write data.
- rf_we  out  1  regfile write enable, registered.
- rf_waddr  out  5  regfile write address, registered.
- rf_wdata  out  32  regfile write data, registered.
- b_pending  out  2  occupancy of B buffer (0..2).

Function
REQ-003 A handshake completes when a_valid && a_ready; B push occurs when b_valid && b_ready.
REQ-004 B buffer: 2-entry FIFO holding {waddr, wdata}; b_ready = (b_pending < 2), independent of same-cycle pop.
REQ-005 No bypass: a B result always enters the FIFO first; minimum latency is push in cycle N, rf_we in cycle N+2.
REQ-006 force = (starve_cnt >= STARVE_LIM) && (b_pending != 0); a_ready = !force, combinational.
REQ-007 Grant to A when a_valid && a_we && a_ready.
REQ-008 Grant to B (FIFO pop of head) when b_pending != 0 and A is not granted. This covers a_valid = 0, a_we = 0, and force = 1.
REQ-009 An A request with a_we = 0 and a_ready = 1 completes its handshake in the same cycle, writes nothing, and leaves the port free for B.
REQ-010 Output registers load every cycle:
- rf_we <= granted && (selected waddr != 0).
- rf_waddr/rf_wdata <= selected source when granted, otherwise hold their previous value.
REQ-011 Writes to register 0 consume their grant (A handshake completes; B entry is popped) but rf_we = 0.
REQ-012 starve_cnt is 4 bits:
- +1, saturating at STARVE_LIM, in each cycle that b_pending != 0 and A is granted.
- Cleared in any cycle that B is granted or b_pending = 0.
REQ-013 Same cycle push and pop: b_pending unchanged; the popped entry is the head; the pushed entry goes to the tail.
REQ-014 b_pending is updated on the clock edge and counts push(+1) and pop(-1).
REQ-015 At most one regfile write per cycle; A and B are never both granted.
REQ-016 No address-hazard reordering: write ordering between A and B to the same register is the producers' responsibility; the arbiter preserves FIFO order within B.

Reset
REQ-017 With reset = 0 at a rising edge, the following are cleared: rf_we, rf_waddr, rf_wdata, b_pending, starve_cnt, FIFO pointers, FIFO contents (to 0).
REQ-018 During reset cycles, a_ready = 1 and b_ready = 1 are permitted, but no handshake is recorded; entries in flight are discarded.
REQ-019 Reset asserted mid-operation drops all buffered B entries; the first cycle after reset release shows rf_we = 0.

Verification
REQ-020 A only: a_valid = 1, a_we = 1, a_waddr = 5, a_wdata = 0x1234 for 1 cycle -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234; a_ready stays 1.
REQ-021 B only: b_valid = 1, b_waddr = 7, b_wdata = 0xDEAD in cycle 0, A idle -> b_pending = 1 in cycle 1; rf_we = 1, rf_waddr = 7, rf_wdata = 0xDEAD in cycle 2; b_pending = 0 in cycle 2.
REQ-022 Starvation, STARVE_LIM = 4: one B entry pending while A writes every cycle ->
- A is granted 4 cycles.
- Cycle 5: a_ready = 0 and B is written.
- Cycle 6: a_ready = 1 and starve_cnt = 0.
REQ-023 Buffer full: 3 back-to-back b_valid cycles while A writes continuously ->
- b_ready = 0 after 2 pushes.
- Third value held by the producer until the first pop.
- FIFO order preserved on rf_waddr.
REQ-024 Register 0 and a_we = 0:
- A with a_waddr = 0 -> handshake completes, rf_we = 0.
- A with a_we = 0 while b_pending = 1 -> A completes and B is written in the same arbitration cycle.
REQ-025 Reset mid-operation: b_pending = 2, reset = 0 for 1 cycle -> b_pending = 0, rf_we = 0; no stale B write follows.

Source files
------------

// File: rtl/rf_wport_arb.sv
// Single register-file write port shared by the in-order writeback stream (A)
// and a 2-entry buffered long-latency result stream (B), with anti-starvation for B.
module rf_wport_arb #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic [4:0]  a_waddr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  b_pending
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } entry_t;

    entry_t      mem_q [2];
    entry_t      head;
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        force_b, grant_a, grant_b, push;
    logic        sel_we;
    logic [4:0]  sel_waddr;
    logic [31:0] sel_wdata;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        force_b   = (starve_q >= LIM) && (cnt_q != 2'd0);
        a_ready   = !force_b;
        b_ready   = (cnt_q < 2'd2);
        grant_a   = a_valid && a_we && !force_b;
        grant_b   = (cnt_q != 2'd0) && !grant_a;
        push      = b_valid && b_ready;

        cnt_d = cnt_q;
        if (push && !grant_b)
            cnt_d = cnt_q + 2'd1;
        else if (!push && grant_b)
            cnt_d = cnt_q - 2'd1;

        // B losing arbitration is the only thing that ages the starvation counter.
        starve_d = starve_q;
        if ((cnt_q == 2'd0) || grant_b)
            starve_d = 4'd0;
        else if (grant_a && (starve_q < LIM))
            starve_d = starve_q + 4'd1;

        sel_waddr = grant_a ? a_waddr : head.waddr;
        sel_wdata = grant_a ? a_wdata : head.wdata;
        sel_we    = (grant_a || grant_b) && (sel_waddr != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: buffer contents are cleared as well so a dropped entry can never resurface.
            for (int i = 0; i < 2; i++)
                mem_q[i] <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            starve_q   <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{waddr: b_waddr, wdata: b_wdata};
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (grant_b)
                rd_ptr_q <= !rd_ptr_q;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            rf_we_q  <= sel_we;
            if (grant_a || grant_b) begin
                rf_waddr_q <= sel_waddr;
                rf_wdata_q <= sel_wdata;
            end
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign b_pending = cnt_q;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: stimulus pushes expected regfile writes into a
// queue, a negedge monitor pops and compares every write the DUT performs.
module tb_rf_wport_arb;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid, b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  b_pending;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    rf_wport_arb #(.STARVE_LIM(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .b_pending(b_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_we = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Monitor: every regfile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(rf_waddr), 32'(e.addr));
                check("wr_data", rf_wdata, e.data);
            end
        end
    end

    logic [16:0] exp_ar;
    logic [16:0] exp_br;

    initial begin
        int na, bi, bp;

        // Reset state
        reset = 1'b0;
        idle();
        tick();
        tick();
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_waddr", 32'(rf_waddr), 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_b_pending", 32'(b_pending), 0);
        reset = 1'b1;
        check("rst_a_ready", 32'(a_ready), 1);
        check("rst_b_ready", 32'(b_ready), 1);

        // A only
        a_valid = 1'b1; a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'h1234;
        check("a_only_ready", 32'(a_ready), 1);
        expect_wr(5'd5, 32'h1234);
        tick();
        idle();
        check("a_only_we", 32'(rf_we), 1);
        check("a_only_ready_after", 32'(a_ready), 1);
        tick();

        // B only: push in cycle 0, pending in 1, written in 2
        b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'hDEAD;
        check("b_only_ready", 32'(b_ready), 1);
        expect_wr(5'd7, 32'hDEAD);
        tick();
        idle();
        check("b_only_pend1", 32'(b_pending), 1);
        check("b_only_no_early_we", 32'(rf_we), 0);
        tick();
        check("b_only_pend2", 32'(b_pending), 0);
        check("b_only_we2", 32'(rf_we), 1);
        tick();

        // Starvation: one B entry, A writes every cycle
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'hB0B0;
        tick();
        b_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            a_valid = 1'b1; a_we = 1'b1; a_waddr = 5'(k); a_wdata = 32'hA000 + 32'(k);
            check("starve_a_ready", 32'(a_ready), 1);
            expect_wr(5'(k), 32'hA000 + 32'(k));
            tick();
        end
        a_waddr = 5'd5; a_wdata = 32'hA005;
        check("starve_force", 32'(a_ready), 0);
        expect_wr(5'd9, 32'hB0B0);
        tick();
        check("starve_release", 32'(a_ready), 1);
        check("starve_pend0", 32'(b_pending), 0);
        expect_wr(5'd5, 32'hA005);
        tick();
        idle();
        tick();
        tick();

        // Buffer full: 3 B results while A writes continuously
        exp_ar = 17'b1_0_1111_0_1111_0_11111;
        exp_br = 17'b0_0000_0000_0100_0011;
        na = 1; bi = 0; bp = 0;
        for (int c = 0; c <= 16; c++) begin
            a_valid = 1'b1; a_we = 1'b1; a_waddr = 5'(na); a_wdata = 32'h100 + 32'(na);
            if (bi < 3) begin
                b_valid = 1'b1; b_waddr = 5'(20 + bi); b_wdata = 32'hC0 + 32'(bi);
            end else begin
                b_valid = 1'b0;
            end
            check("full_a_ready", 32'(a_ready), 32'(exp_ar[c]));
            if (bi < 3)
                check("full_b_ready", 32'(b_ready), 32'(exp_br[c]));
            if (c == 2)
                check("full_pend2", 32'(b_pending), 2);
            if (exp_ar[c]) begin
                expect_wr(5'(na), 32'h100 + 32'(na));
                na++;
            end else begin
                expect_wr(5'(20 + bp), 32'hC0 + 32'(bp));
                bp++;
            end
            if (bi < 3 && exp_br[c])
                bi++;
            tick();
        end
        idle();
        check("full_drained", 32'(b_pending), 0);
        tick();

        // Register 0 from A: handshake, no write
        a_valid = 1'b1; a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF;
        check("r0_a_ready", 32'(a_ready), 1);
        tick();
        idle();
        check("r0_a_no_we", 32'(rf_we), 0);

        // a_we = 0 with B pending: both complete in the same cycle
        b_valid = 1'b1; b_waddr = 5'd3; b_wdata = 32'h33;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_waddr = 5'd4; a_wdata = 32'h44;
        check("nowe_a_ready", 32'(a_ready), 1);
        check("nowe_pend1", 32'(b_pending), 1);
        expect_wr(5'd3, 32'h33);
        tick();
        idle();
        check("nowe_pend0", 32'(b_pending), 0);
        check("nowe_b_we", 32'(rf_we), 1);

        // Register 0 from B: popped, no write
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'h77;
        tick();
        b_valid = 1'b0;
        check("r0_b_pend1", 32'(b_pending), 1);
        tick();
        check("r0_b_pend0", 32'(b_pending), 0);
        check("r0_b_no_we", 32'(rf_we), 0);
        tick();

        // Reset mid-operation with two buffered B entries
        a_valid = 1'b1; a_we = 1'b1; a_waddr = 5'd1; a_wdata = 32'h61;
        b_valid = 1'b1; b_waddr = 5'd30; b_wdata = 32'h30;
        expect_wr(5'd1, 32'h61);
        tick();
        a_waddr = 5'd2; a_wdata = 32'h62;
        b_waddr = 5'd31; b_wdata = 32'h31;
        check("mrst_a_ready", 32'(a_ready), 1);
        expect_wr(5'd2, 32'h62);
        tick();
        idle();
        check("mrst_pend2", 32'(b_pending), 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mrst_pend0", 32'(b_pending), 0);
        check("mrst_no_we", 32'(rf_we), 0);
        for (int i = 0; i < 5; i++)
            tick();

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
